// File: rtl/inv_key_expansion.sv
// -----------------------------------------------------------------------------
// inv_key_expansion
//
// Purpose: regenerates the AES-128 round keys in reverse order. Given the last
// round key (round 10), it emits round keys 10, 9, ..., 0, one per output
// handshake. Each backward step takes one cycle to register
// SubWord(RotWord(w3^w2)) and one cycle to rebuild the previous key.
//
// Ports:
//   clk          in   1    rising-edge clock
//   rst          in   1    asynchronous active-high reset
//   valid_i      in   1    key_i holds a round-10 key
//   ready_o      out  1    idle and accepting key_i
//   key_i        in   128  round-10 key, word0 in [127:96]
//   valid_o      out  1    round_key_o holds a valid round key
//   ready_i      in   1    consumer accepts round_key_o
//   round_key_o  out  128  current round key, word0 in [127:96]
//   round_idx_o  out  4    round number of round_key_o (10 down to 0)
//   last_o       out  1    high with valid_o for round 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and ready
// is low. ready_o depends only on state, never on valid_i; valid_o depends only
// on state, never on ready_i.
//
// Configuration macro: INV_RCON_LUT_EN
//   defined   -> round constant comes from an 11-entry table indexed by round
//   undefined -> round constant register stepped backwards by inv_xtime
// Both builds produce cycle-identical outputs.
// -----------------------------------------------------------------------------

// Four forward AES S-boxes applied bytewise to a 32-bit word.
module sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Element 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign word_o[31:24] = SBOX[word_i[31:24]];
  assign word_o[23:16] = SBOX[word_i[23:16]];
  assign word_o[15:8]  = SBOX[word_i[15:8]];
  assign word_o[7:0]   = SBOX[word_i[7:0]];

endmodule

module inv_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] key_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_idx_o,
  output logic         last_o
);

  localparam int Nk    = 4;
  localparam int Nr    = 10;
  localparam int KEY_W = 128;

  localparam logic [3:0] IDX_FIRST = 4'(Nr);
  localparam logic [7:0] RCON_LAST = 8'h36;

  // State is readable as state_q for checkers bound to this block.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_SUB  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic [3:0]         idx_q,   idx_d;
  logic [31:0]        temp_q,  temp_d;
  logic [7:0]         rcon_cur;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] prev_w3;
  logic [31:0] rot_w;
  logic [31:0] sub_w;

  // Undo the shift-and-reduce of xtime. An odd value carried the x^8 term of
  // the reduction polynomial, which lands in bit 7 after the right shift.
  function automatic logic [7:0] inv_xtime(input logic [7:0] n);
    logic [7:0] r;
    if (n[0]) r = ((n ^ 8'h1b) >> 1) | 8'h80;
    else      r = n >> 1;
    return r;
  endfunction

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Word 3 of the previous round key is w3 ^ w2 of the current one.
  assign prev_w3 = w3 ^ w2;
  assign rot_w   = {prev_w3[23:0], prev_w3[31:24]};

  sub_word u_sub_word (
    .word_i (rot_w),
    .word_o (sub_w)
  );

`ifdef INV_RCON_LUT_EN
  // Round constant used when stepping from round idx to idx-1.
  always_comb begin
    rcon_cur = 8'h00;
    case (idx_q)
      4'd10:   rcon_cur = 8'h36;
      4'd9:    rcon_cur = 8'h1b;
      4'd8:    rcon_cur = 8'h80;
      4'd7:    rcon_cur = 8'h40;
      4'd6:    rcon_cur = 8'h20;
      4'd5:    rcon_cur = 8'h10;
      4'd4:    rcon_cur = 8'h08;
      4'd3:    rcon_cur = 8'h04;
      4'd2:    rcon_cur = 8'h02;
      4'd1:    rcon_cur = 8'h01;
      4'd0:    rcon_cur = 8'h00;
      default: rcon_cur = 8'h00;
    endcase
  end
`else
  logic [7:0] rcon_q, rcon_d;

  assign rcon_cur = rcon_q;

  always_comb begin
    rcon_d = rcon_q;
    if (state_q == S_IDLE && valid_i) rcon_d = RCON_LAST;
    else if (state_q == S_STEP)       rcon_d = inv_xtime(rcon_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rcon_q <= RCON_LAST;
    else     rcon_q <= rcon_d;
  end
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      temp_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      temp_q  <= temp_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid_i) state_d = S_OUT;
      S_OUT:  if (ready_i) state_d = (idx_q == 4'd0) ? S_IDLE : S_SUB;
      S_SUB:  state_d = S_STEP;
      S_STEP: state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    key_d  = key_q;
    idx_d  = idx_q;
    temp_d = temp_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          key_d = key_i;
          idx_d = IDX_FIRST;
        end
      end
      S_SUB: temp_d = sub_w;
      S_STEP: begin
        key_d = {w0 ^ temp_q ^ {rcon_cur, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        idx_d = idx_q - 4'd1;
      end
      default: ;
    endcase
  end

  // Outputs: Moore-style, straight from state and registers.
  always_comb begin
    ready_o     = (state_q == S_IDLE);
    valid_o     = (state_q == S_OUT);
    last_o      = (state_q == S_OUT) && (idx_q == 4'd0);
    round_key_o = key_q;
    round_idx_o = idx_q;
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_inv_key_expansion
//
// Bench for inv_key_expansion. Expected round keys come from a forward AES-128
// key schedule computed here from a cipher key, with the S-box derived from
// GF(2^8) inversion plus the affine map. The DUT is fed the forward round-10
// key and must hand back rounds 10..0.
// -----------------------------------------------------------------------------
module tb_inv_key_expansion;

  logic         clk;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] key_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] round_key_o;
  logic [3:0]   round_idx_o;
  logic         last_o;

  int errors = 0;
  int checks = 0;

  inv_key_expansion dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .key_i       (key_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .round_key_o (round_key_o),
    .round_idx_o (round_idx_o),
    .last_o      (last_o)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk [0:10];
  logic [127:0] exp_q[$];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    d = d << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward AES-128 schedule: fills rk[0..10] from the cipher key.
  task automatic expand_key(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(rk[r]);
  endtask

  // ---------------------------------------------------------------- driver / monitor
  logic [127:0] obs_key_q[$];
  logic [3:0]   obs_idx_q[$];
  logic         obs_last_q[$];
  int           lat_q[$];
  bit           timeout_flag;
  int           stable_errs;
  int           ready_errs;

  // Presents one round-10 key, then consumes up to max_hs output handshakes
  // with ready_i high ready_pct percent of the time. With hold_valid set,
  // valid_i stays high carrying next_key for the whole run.
  task automatic run_key(input logic [127:0] key, input int ready_pct, input int max_hs,
                         input bit hold_valid, input logic [127:0] next_key);
    int           cyc;
    int           last_ev;
    bit           seen_valid;
    bit           prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    obs_key_q.delete(); obs_idx_q.delete(); obs_last_q.delete(); lat_q.delete();
    timeout_flag = 0; stable_errs = 0; ready_errs = 0;
    prev_key = '0; prev_idx = '0;
    @(negedge clk);
    cyc = 0;
    while (!ready_o && cyc < 50) begin @(negedge clk); cyc++; end
    if (!ready_o) timeout_flag = 1;
    valid_i = 1'b1; key_i = key; ready_i = 1'b0;
    @(posedge clk);
    cyc = 0; last_ev = 0; seen_valid = 0; prev_stall = 0;
    while (obs_key_q.size() < max_hs && cyc < 500) begin
      @(negedge clk); cyc++;
      if (hold_valid) begin valid_i = 1'b1; key_i = next_key; end
      else valid_i = 1'b0;
      ready_i = ($urandom_range(99) < ready_pct);
      if (prev_stall && (!valid_o || round_key_o !== prev_key || round_idx_o !== prev_idx))
        stable_errs++;
      if (valid_o && ready_o) ready_errs++;
      if (valid_o && !seen_valid) begin lat_q.push_back(cyc - last_ev); seen_valid = 1; end
      if (valid_o && ready_i) begin
        obs_key_q.push_back(round_key_o);
        obs_idx_q.push_back(round_idx_o);
        obs_last_q.push_back(last_o);
        last_ev = cyc; seen_valid = 0; prev_stall = 0;
      end else begin
        prev_stall = valid_o; prev_key = round_key_o; prev_idx = round_idx_o;
      end
    end
    if (obs_key_q.size() < max_hs) timeout_flag = 1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    if (!hold_valid) valid_i = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; key_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o got=%b want=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o got=%b want=1", ready_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last_o got=%b want=0", last_o); end
    checks++; if (round_key_o !== 128'h0) begin errors++; $display("FAIL reset_round_key got=%h want=0", round_key_o); end
    checks++; if (round_idx_o !== 4'h0) begin errors++; $display("FAIL reset_round_idx got=%0d want=0", round_idx_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_known_vector(input int ready_pct, input string tag);
    logic [127:0] exp_k;
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ready_pct, 11, 0, '0);
    checks++;
    if (timeout_flag || obs_key_q.size() != 11) begin
      errors++; $display("FAIL %s_count got=%0d want=11 timeout=%0d", tag, obs_key_q.size(), timeout_flag);
    end
    if (obs_key_q.size() == 11) begin
      checks++; if (obs_key_q[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL %s_round10 got=%h", tag, obs_key_q[0]); end
      checks++; if (obs_key_q[1] !== 128'hac7766f319fadc2128d12941575c006e) begin errors++; $display("FAIL %s_round9 got=%h", tag, obs_key_q[1]); end
      checks++; if (obs_key_q[10] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL %s_round0 got=%h", tag, obs_key_q[10]); end
      checks++; if (obs_last_q[10] !== 1'b1) begin errors++; $display("FAIL %s_last0 got=%b want=1", tag, obs_last_q[10]); end
    end
    for (int r = 0; r < obs_key_q.size(); r++) begin
      exp_k = exp_q.pop_front();
      checks++; if (obs_key_q[r] !== exp_k) begin errors++; $display("FAIL %s_key r=%0d got=%h want=%h", tag, r, obs_key_q[r], exp_k); end
      checks++; if (obs_idx_q[r] !== 4'(10 - r)) begin errors++; $display("FAIL %s_idx r=%0d got=%0d want=%0d", tag, r, obs_idx_q[r], 10 - r); end
      checks++; if (obs_last_q[r] !== (r == 10)) begin errors++; $display("FAIL %s_last r=%0d got=%b", tag, r, obs_last_q[r]); end
    end
    for (int i = 0; i < lat_q.size(); i++) begin
      checks++;
      if (lat_q[i] != ((i == 0) ? 1 : 3)) begin
        errors++; $display("FAIL %s_latency n=%0d got=%0d want=%0d", tag, i, lat_q[i], (i == 0) ? 1 : 3);
      end
    end
    checks++; if (stable_errs != 0) begin errors++; $display("FAIL %s_stable got=%0d want=0", tag, stable_errs); end
    checks++; if (ready_errs != 0) begin errors++; $display("FAIL %s_ready_busy got=%0d want=0", tag, ready_errs); end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] ck;
    logic [127:0] exp_k;
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_key(ck);
    run_key(rk[10], 100, 6, 0, '0);
    checks++; if (obs_idx_q.size() != 6 || obs_idx_q[5] !== 4'd5) begin errors++; $display("FAIL midrst_reach_round5 n=%0d", obs_idx_q.size()); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid_o got=%b want=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready_o got=%b want=1", ready_o); end
    checks++; if (round_key_o !== 128'h0) begin errors++; $display("FAIL midrst_round_key got=%h want=0", round_key_o); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL midrst_idle i=%0d valid=%b ready=%b", i, valid_o, ready_o); end
    end
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand_key(ck);
    run_key(rk[10], 60, 11, 0, '0);
    checks++; if (timeout_flag || obs_key_q.size() != 11) begin errors++; $display("FAIL midrst_rerun_count got=%0d want=11", obs_key_q.size()); end
    for (int r = 0; r < obs_key_q.size(); r++) begin
      exp_k = exp_q.pop_front();
      checks++; if (obs_key_q[r] !== exp_k || obs_idx_q[r] !== 4'(10 - r)) begin
        errors++; $display("FAIL midrst_rerun_key r=%0d got=%h/%0d want=%h/%0d", r, obs_key_q[r], obs_idx_q[r], exp_k, 10 - r);
      end
    end
  endtask

  task automatic test_valid_held();
    logic [127:0] ck_a, ck_b, a10, b10;
    logic [127:0] exp_k;
    ck_a = {$urandom, $urandom, $urandom, $urandom};
    ck_b = {$urandom, $urandom, $urandom, $urandom};
    expand_key(ck_b); b10 = rk[10];
    expand_key(ck_a); a10 = rk[10];
    run_key(a10, 70, 11, 1, b10);
    checks++; if (timeout_flag || obs_key_q.size() != 11) begin errors++; $display("FAIL held_count got=%0d want=11", obs_key_q.size()); end
    checks++; if (ready_errs != 0) begin errors++; $display("FAIL held_ready_busy got=%0d want=0", ready_errs); end
    for (int r = 0; r < obs_key_q.size(); r++) begin
      exp_k = exp_q.pop_front();
      checks++; if (obs_key_q[r] !== exp_k || obs_idx_q[r] !== 4'(10 - r)) begin
        errors++; $display("FAIL held_key_a r=%0d got=%h/%0d want=%h/%0d", r, obs_key_q[r], obs_idx_q[r], exp_k, 10 - r);
      end
    end
    // Right after the final handshake the block must be idle, not already
    // holding the second key.
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL held_idle_after_last valid=%b ready=%b want 0/1", valid_o, ready_o); end
    expand_key(ck_b);
    run_key(b10, 100, 11, 0, '0);
    checks++; if (timeout_flag || obs_key_q.size() != 11) begin errors++; $display("FAIL held_b_count got=%0d want=11", obs_key_q.size()); end
    for (int r = 0; r < obs_key_q.size(); r++) begin
      exp_k = exp_q.pop_front();
      checks++; if (obs_key_q[r] !== exp_k || obs_idx_q[r] !== 4'(10 - r)) begin
        errors++; $display("FAIL held_key_b r=%0d got=%h/%0d want=%h/%0d", r, obs_key_q[r], obs_idx_q[r], exp_k, 10 - r);
      end
    end
  endtask

  task automatic test_round_trip_random();
    logic [127:0] ck;
    logic [127:0] exp_k;
    for (int n = 0; n < 100; n++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand_key(ck);
      run_key(rk[10], $urandom_range(100, 50), 11, 0, '0);
      checks++; if (timeout_flag || obs_key_q.size() != 11) begin errors++; $display("FAIL rt_count key=%0d got=%0d want=11", n, obs_key_q.size()); end
      checks++; if (stable_errs != 0) begin errors++; $display("FAIL rt_stable key=%0d got=%0d want=0", n, stable_errs); end
      for (int r = 0; r < obs_key_q.size(); r++) begin
        exp_k = exp_q.pop_front();
        checks++;
        if (obs_key_q[r] !== exp_k || obs_idx_q[r] !== 4'(10 - r) || obs_last_q[r] !== (r == 10)) begin
          errors++; $display("FAIL rt_key key=%0d r=%0d got=%h/%0d/%b want=%h/%0d", n, r, obs_key_q[r], obs_idx_q[r], obs_last_q[r], exp_k, 10 - r);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; key_i = '0;
    build_sbox();
    test_reset();
    test_known_vector(100, "basic");
    test_known_vector(40, "stall");
    test_reset_mid_run();
    test_valid_held();
    test_round_trip_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
